// File: rtl/la_core_bridge_pkg.sv
// Shared definitions for the LA host<->core bridge: LA bus bit map,
// command opcodes and the control FSM state encoding.
package la_core_bridge_pkg;

  localparam int LA_W = 128;

  // Host -> block fields on la_data_in
  localparam int LA_DATA_LSB = 0;
  localparam int LA_ADDR_LSB = 32;
  localparam int LA_CMD_BIT  = 96;
  localparam int LA_OP_LSB   = 97;
  localparam int LA_POP_BIT  = 99;

  // Block -> host fields on la_data_out
  localparam int LO_HEAD_LSB  = 0;
  localparam int LO_NONEMPTY  = 32;
  localparam int LO_OVF       = 33;
  localparam int LO_PENDING   = 34;
  localparam int LO_STATE_LSB = 35;
  localparam int LO_COUNT_LSB = 37;
  localparam int LO_ACK       = 41;
  localparam int LO_ERR       = 42;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_WORD = 2'd1,
    OP_RUN  = 2'd2,
    OP_HALT = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ST_HALT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_WAIT_IN = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for core output words. A push while full is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and
// the caller decides what to do about it. Head reads 0 when empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_en;
  logic              pop_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers (wrap naturally since DEPTH is a power of 2) and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/la_core_bridge.sv
// Host<->core bridge. The host toggles LA bit 96 to issue a command and
// bit 99 to pop the output FIFO; each toggle is one event. Commands load
// core memory, start/halt the core and deliver input words to it.
//
// Handshake summary: a command is accepted in the cycle its toggle edge is
// seen (oenb bit low); fields are sampled in that same cycle, the effect and
// the ack toggle (la_data_out[41]) appear one cycle later. Core input uses a
// level request (core_in_req) answered by a single-cycle core_in_valid; core
// output uses a single-cycle core_out_valid with no back-pressure.
module la_core_bridge
  import la_core_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [127:0]      la_data_in,
  input  logic [127:0]      la_oenb,
  output logic [127:0]      la_data_out,
  output logic              core_rst_n,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              core_in_req,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_valid,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (DATA_W > 32 || DATA_W < 1) begin : g_bad_data_w
    $error("la_core_bridge: DATA_W must be 1..32");
  end
  if (ADDR_W > 20 || ADDR_W < 1) begin : g_bad_addr_w
    $error("la_core_bridge: ADDR_W must be 1..20");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("la_core_bridge: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [LA_W-1:0]   la_in;
  logic              cmd_prev;
  logic              pop_prev;
  logic              cmd_ev;
  logic              pop_ev;
  logic              halt_cmd;
  opcode_e           op;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;

  state_e            state;
  logic              ack;
  logic              err;
  logic              pending;
  logic              ovf;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              drop;
  logic              unused_la;

  // Only bits whose oenb is low carry host data
  assign la_in     = la_data_in & ~la_oenb;
  assign unused_la = ^la_in;

  assign cmd_ev   = (la_data_in[LA_CMD_BIT] != cmd_prev) & ~la_oenb[LA_CMD_BIT];
  assign pop_ev   = (la_data_in[LA_POP_BIT] != pop_prev) & ~la_oenb[LA_POP_BIT];
  assign op       = opcode_e'(la_in[LA_OP_LSB +: 2]);
  assign f_addr   = la_in[LA_ADDR_LSB +: ADDR_W];
  assign f_data   = la_in[LA_DATA_LSB +: DATA_W];
  assign halt_cmd = cmd_ev & (op == OP_HALT);

  // A word arriving while full with no simultaneous pop is lost
  assign drop = core_out_valid & fifo_full & ~pop_ev;

  // Toggle history: follows the raw LA bits every cycle
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cmd_prev <= 1'b0;
      pop_prev <= 1'b0;
    end else begin
      cmd_prev <= la_data_in[LA_CMD_BIT];
      pop_prev <= la_data_in[LA_POP_BIT];
    end
  end

  // Control FSM with all its registered outputs; HALT overrides every state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= ST_HALT;
      ack           <= 1'b0;
      err           <= 1'b0;
      pending       <= 1'b0;
      core_rst_n    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      core_in_data  <= '0;
      core_in_valid <= 1'b0;
    end else begin
      mem_we        <= 1'b0;
      core_in_valid <= 1'b0;
      if (cmd_ev) ack <= ~ack;
      if (halt_cmd) begin
        state      <= ST_HALT;
        core_rst_n <= 1'b0;
        pending    <= 1'b0;
        err        <= 1'b0;
      end else begin
        case (state)
          ST_HALT: begin
            if (cmd_ev && op == OP_WORD) begin
              mem_we    <= 1'b1;
              mem_addr  <= f_addr;
              mem_wdata <= f_data;
            end else if (cmd_ev && op == OP_RUN) begin
              state      <= ST_RUN;
              core_rst_n <= 1'b1;
            end
          end
          ST_RUN: begin
            if (cmd_ev && op == OP_WORD) err <= 1'b1;
            if (core_in_req) begin
              state   <= ST_WAIT_IN;
              pending <= 1'b1;
            end
          end
          ST_WAIT_IN: begin
            if (cmd_ev && op == OP_WORD) begin
              core_in_data  <= f_data;
              core_in_valid <= 1'b1;
              pending       <= 1'b0;
              state         <= ST_RUN;
            end else if (cmd_ev && op == OP_RUN) begin
              err <= 1'b1;
            end
          end
          default: state <= ST_HALT;
        endcase
      end
    end
  end

  // Sticky overflow flag, cleared by a HALT command
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ovf <= 1'b0;
    end else if (halt_cmd) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .push      (core_out_valid),
    .push_data (core_out_data),
    .pop       (pop_ev),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Host-visible status word; unused bits stay 0
  always_comb begin
    la_data_out                      = '0;
    la_data_out[LO_HEAD_LSB +: 32]   = 32'(fifo_head);
    la_data_out[LO_NONEMPTY]         = ~fifo_empty;
    la_data_out[LO_OVF]              = ovf;
    la_data_out[LO_PENDING]          = pending;
    la_data_out[LO_STATE_LSB +: 2]   = state;
    la_data_out[LO_COUNT_LSB +: 4]   = 4'(fifo_count);
    la_data_out[LO_ACK]              = ack;
    la_data_out[LO_ERR]              = err;
  end

endmodule

// File: tb/tb_la_core_bridge.sv
// Bench for la_core_bridge: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model of the bridge.
module tb_la_core_bridge;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 20;
  localparam int DEPTH  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0]      la_data_in = '0;
  logic [127:0]      la_oenb    = '0;
  logic [127:0]      la_data_out;
  logic              core_rst_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_in_req = 1'b0;
  logic [DATA_W-1:0] core_in_data;
  logic              core_in_valid;
  logic [DATA_W-1:0] core_out_data = '0;
  logic              core_out_valid = 1'b0;

  la_core_bridge #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .la_data_in     (la_data_in),
    .la_oenb        (la_oenb),
    .la_data_out    (la_data_out),
    .core_rst_n     (core_rst_n),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .core_in_req    (core_in_req),
    .core_in_data   (core_in_data),
    .core_in_valid  (core_in_valid),
    .core_out_data  (core_out_data),
    .core_out_valid (core_out_valid)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];     // expected FIFO contents, head at index 0
  int          m_state;      // 0 halt, 1 run, 2 waiting for input
  bit          m_ack, m_err, m_ovf, m_pend, m_rstn;
  bit          m_we, m_ivalid;
  logic [19:0] m_addr;
  logic [31:0] m_wdata, m_idata;
  bit          m_cmd_prev, m_pop_prev;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_state = 0; m_ack = 0; m_err = 0; m_ovf = 0; m_pend = 0; m_rstn = 0;
    m_we = 0; m_ivalid = 0; m_addr = '0; m_wdata = '0; m_idata = '0;
    m_cmd_prev = 0; m_pop_prev = 0;
  endfunction

  // One clock of bridge behaviour, from the current bench-driven inputs
  function automatic void model_step();
    logic [127:0] f      = la_data_in & ~la_oenb;
    bit           cmd_ev = (la_data_in[96] != m_cmd_prev) && !la_oenb[96];
    bit           pop_ev = (la_data_in[99] != m_pop_prev) && !la_oenb[99];
    logic [1:0]   op     = f[98:97];
    bit           halt   = cmd_ev && (op == 2'b11);
    bit           full   = (exp_q.size() == DEPTH);
    bit           pop_do = pop_ev && (exp_q.size() != 0);
    m_cmd_prev = la_data_in[96];
    m_pop_prev = la_data_in[99];
    m_we = 0;
    m_ivalid = 0;
    if (cmd_ev) m_ack = !m_ack;
    if (halt) m_ovf = 0;
    else if (core_out_valid && full && !pop_do) m_ovf = 1;
    if (pop_do) void'(exp_q.pop_front());
    if (core_out_valid && (!full || pop_do)) exp_q.push_back(core_out_data);
    if (halt) begin
      m_state = 0; m_rstn = 0; m_pend = 0; m_err = 0;
    end else if (m_state == 0) begin
      if (cmd_ev && op == 2'b01) begin
        m_we = 1; m_addr = f[51:32]; m_wdata = f[31:0];
      end else if (cmd_ev && op == 2'b10) begin
        m_state = 1; m_rstn = 1;
      end
    end else if (m_state == 1) begin
      if (cmd_ev && op == 2'b01) m_err = 1;
      if (core_in_req) begin m_state = 2; m_pend = 1; end
    end else begin
      if (cmd_ev && op == 2'b01) begin
        m_ivalid = 1; m_idata = f[31:0]; m_pend = 0; m_state = 1;
      end else if (cmd_ev && op == 2'b10) m_err = 1;
    end
  endfunction

  function automatic logic [127:0] exp_la();
    logic [127:0] v = '0;
    v[31:0]  = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    v[32]    = (exp_q.size() != 0);
    v[33]    = m_ovf;
    v[34]    = m_pend;
    v[36:35] = 2'(m_state);
    v[40:37] = 4'(exp_q.size());
    v[41]    = m_ack;
    v[42]    = m_err;
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_la"},    la_data_out,   exp_la());
    check({tag, "_we"},    mem_we,        m_we);
    check({tag, "_addr"},  mem_addr,      m_addr);
    check({tag, "_wdata"}, mem_wdata,     m_wdata);
    check({tag, "_crst"},  core_rst_n,    m_rstn);
    check({tag, "_ival"},  core_in_valid, m_ivalid);
    check({tag, "_idata"}, core_in_data,  m_idata);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, advance the model one clock,
  // then compare at the next falling edge.
  task automatic step(input bit do_cmd, input logic [1:0] op, input logic [19:0] addr,
                      input logic [31:0] data, input bit do_pop, input bit push,
                      input logic [31:0] pdata, input string tag);
    la_data_in[31:0]  = data;
    la_data_in[51:32] = addr;
    la_data_in[98:97] = op;
    if (do_cmd) la_data_in[96] = ~la_data_in[96];
    if (do_pop) la_data_in[99] = ~la_data_in[99];
    core_out_valid = push;
    core_out_data  = pdata;
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(0, 2'b00, 20'h0, 32'h0, 0, 0, 32'h0, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_la"},   la_data_out,   128'h0);
    check({tag, "_crst"}, core_rst_n,    1'b0);
    check({tag, "_we"},   mem_we,        1'b0);
    check({tag, "_ival"}, core_in_valid, 1'b0);
    check({tag, "_addr"}, mem_addr,      20'h0);
    check({tag, "_idat"}, core_in_data,  32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ack_before;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle("post_reset");

    // 1: memory load while halted
    step(1, 2'b01, 20'h00010, 32'hDEADBEEF, 0, 0, 32'h0, "t1_word");
    check("t1_we_pulse", mem_we, 1'b1);
    check("t1_addr", mem_addr, 20'h00010);
    check("t1_data", mem_wdata, 32'hDEADBEEF);
    check("t1_ack", la_data_out[41], 1'b1);
    idle("t1_idle");
    check("t1_we_end", mem_we, 1'b0);

    // 2: run, input request, deliver input word
    step(1, 2'b10, 20'h0, 32'h0, 0, 0, 32'h0, "t2_run");
    check("t2_crst", core_rst_n, 1'b1);
    core_in_req = 1'b1;
    idle("t2_req");
    check("t2_pending", la_data_out[34], 1'b1);
    step(1, 2'b01, 20'h0, 32'h12345678, 0, 0, 32'h0, "t2_word");
    check("t2_ival", core_in_valid, 1'b1);
    check("t2_idata", core_in_data, 32'h12345678);
    check("t2_state", la_data_out[36:35], 2'd1);
    check("t2_pend_clr", la_data_out[34], 1'b0);
    core_in_req = 1'b0;
    idle("t2_idle");
    check("t2_ival_end", core_in_valid, 1'b0);

    // 3: overfill, then drain past empty
    for (int i = 1; i <= 5; i++) step(0, 2'b00, 20'h0, 32'h0, 0, 1, 32'(i), "t3_push");
    check("t3_count", la_data_out[40:37], 4'd4);
    check("t3_ovf", la_data_out[33], 1'b1);
    check("t3_head", la_data_out[31:0], 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("t3_pop_head", la_data_out[31:0], 32'(i));
      step(0, 2'b00, 20'h0, 32'h0, 1, 0, 32'h0, "t3_pop");
    end
    step(0, 2'b00, 20'h0, 32'h0, 1, 0, 32'h0, "t3_pop_empty");
    check("t3_count_empty", la_data_out[40:37], 4'd0);

    // 4: halt clears overflow; push+pop when full
    step(1, 2'b11, 20'h0, 32'h0, 0, 0, 32'h0, "t4_halt");
    for (int i = 10; i <= 13; i++) step(0, 2'b00, 20'h0, 32'h0, 0, 1, 32'(i), "t4_fill");
    check("t4_ovf0", la_data_out[33], 1'b0);
    step(0, 2'b00, 20'h0, 32'h0, 1, 1, 32'd14, "t4_pushpop");
    check("t4_count", la_data_out[40:37], 4'd4);
    check("t4_head", la_data_out[31:0], 32'd11);
    check("t4_ovf", la_data_out[33], 1'b0);

    // 5: rejected WORD in RUN, then HALT
    step(1, 2'b10, 20'h0, 32'h0, 0, 0, 32'h0, "t5_run");
    ack_before = m_ack;
    step(1, 2'b01, 20'h00055, 32'h1, 0, 0, 32'h0, "t5_word");
    check("t5_no_we", mem_we, 1'b0);
    check("t5_err", la_data_out[42], 1'b1);
    check("t5_ack", la_data_out[41], !ack_before);
    step(1, 2'b11, 20'h0, 32'h0, 0, 0, 32'h0, "t5_halt");
    check("t5_err_clr", la_data_out[42], 1'b0);
    check("t5_crst", core_rst_n, 1'b0);

    // 6: masked toggle is not an event; async reset mid-WAIT_IN
    ack_before = m_ack;
    la_oenb[96] = 1'b1;
    step(1, 2'b10, 20'h0, 32'h0, 0, 0, 32'h0, "t6_masked");
    check("t6_state", la_data_out[36:35], 2'd0);
    check("t6_ack", la_data_out[41], ack_before);
    la_oenb[96] = 1'b0;
    idle("t6_unmask");
    step(1, 2'b10, 20'h0, 32'h0, 0, 0, 32'h0, "t6_run");
    core_in_req = 1'b1;
    idle("t6_req");
    check("t6_wait", la_data_out[36:35], 2'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t6_async");
    la_data_in  = '0;
    core_in_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("t6_held");
    rst_n = 1'b1;
    idle("t6_release");
    check("t6_no_we", mem_we, 1'b0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if (m_ivalid) core_in_req = 1'b0;
      else if (!core_in_req && $urandom_range(0, 5) == 0) core_in_req = 1'b1;
      la_oenb[96] = ($urandom_range(0, 9) == 0);
      la_oenb[99] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
           20'($urandom_range(0, 20'hFFFFF)), $urandom(),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom(), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
